// File: rtl/decode_pkg.sv
// Shared constants for the decode path: unpacker geometry and the END code
// that decode_ctl stops on.
package decode_pkg;

  localparam int IN_W  = 32;
  localparam int OUT_W = 13;
  localparam int BUF_W = 64;
  localparam int CNT_W = 7;

  localparam logic [8:0] END_CODE = 9'b1_1000_0000;

  // Widths outside 1..OUT_W are protocol errors and never shift the buffer.
  function automatic logic width_legal(input logic [3:0] w);
    return (w != 4'd0) && (w <= 4'(OUT_W));
  endfunction

endpackage

// File: rtl/decode_bitbuf.sv
// MSB-aligned bit buffer: shift out sh bits, then insert a word at the
// remaining fill level. Bits below the valid count are always zero.
module decode_bitbuf
  import decode_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [3:0]       sh_i,
  input  logic             load_i,
  input  logic [IN_W-1:0]  word_i,
  output logic [OUT_W-1:0] top_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [BUF_W-1:0] bits_q, bits_d, bits_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_s;

  always_comb begin
    bits_s = bits_q << sh_i;
    cnt_s  = cnt_q - CNT_W'(sh_i);
    bits_d = bits_s;
    cnt_d  = cnt_s;
    if (load_i) begin
      // Shift happens before insert, so a same-cycle word lands at cnt_s.
      bits_d = bits_s | ({word_i, {IN_W{1'b0}}} >> cnt_s);
      cnt_d  = cnt_s + CNT_W'(IN_W);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
    end
  end

  assign top_o = bits_q[BUF_W-1 -: OUT_W];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/decode_unpack.sv
// Bit-stream unpacker: 32-bit words in, 13-bit peek window out, variable-width consume.
// Define DECODE_UNPACK_BITCNT_EN to add the saturating bit_cnt_o consumed-bits counter.
module decode_unpack
  import decode_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic             in_valid_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic [OUT_W-1:0] stream_data_o,
  output logic             stream_valid_o,
  input  logic [3:0]       stream_width_i,
  input  logic             stream_ack_i,
  output logic             drained_o,
`ifdef DECODE_UNPACK_BITCNT_EN
  output logic [31:0]      bit_cnt_o,
`endif
  output logic             err_o
);

  logic             clr;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       sh;
  logic             accept;
  logic             last_q, last_d;
  logic             err_q, err_d;

  assign clr = rst_i | flush_i;

  decode_bitbuf u_bitbuf (
    .clk_i  (clk_i),
    .clr_i  (clr),
    .sh_i   (sh),
    .load_i (accept),
    .word_i (in_data_i),
    .top_o  (stream_data_o),
    .cnt_o  (cnt)
  );

  assign stream_valid_o = (cnt >= CNT_W'(OUT_W)) | (last_q & (cnt != '0));
  // Registered cnt only: worst case cnt=32 plus a word without any ack stays <= 64.
  assign in_ready_o     = ~rst_i & ~flush_i & ~last_q & (cnt <= CNT_W'(IN_W));
  assign accept         = in_valid_i & in_ready_o;
  assign drained_o      = last_q & (cnt == '0);
  assign err_o          = err_q;

  always_comb begin
    sh     = 4'd0;
    err_d  = err_q;
    last_d = last_q;
    if (stream_ack_i) begin
      if (!stream_valid_o || !width_legal(stream_width_i)) begin
        err_d = 1'b1;
      end else if (CNT_W'(stream_width_i) > cnt) begin
        // Over-consume in the tail: drain what is left and flag it.
        sh    = cnt[3:0];
        err_d = 1'b1;
      end else begin
        sh = stream_width_i;
      end
    end
    if (accept && in_last_i) last_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

`ifdef DECODE_UNPACK_BITCNT_EN
  logic [31:0] bc_q;
  logic [32:0] bc_sum;

  assign bc_sum    = {1'b0, bc_q} + 33'(sh);
  assign bit_cnt_o = bc_q;

  always_ff @(posedge clk_i) begin
    if (clr)            bc_q <= '0;
    else if (bc_sum[32]) bc_q <= '1;
    else                 bc_q <= bc_sum[31:0];
  end
`endif

endmodule

// File: tb/tb_decode_unpack.sv
// Scoreboard bench for decode_unpack: a bit-queue reference model predicts each
// cycle's outputs, a negedge monitor pops and compares.
module tb_decode_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [12:0] stream_data;
  logic        stream_valid;
  logic [3:0]  stream_width = 4'd0;
  logic        stream_ack = 1'b0;
  logic        drained;
  logic        err;
`ifdef DECODE_UNPACK_BITCNT_EN
  logic [31:0] bit_cnt;
`endif

  always #5 clk = ~clk;

  decode_unpack dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_last_i      (in_last),
    .in_ready_o     (in_ready),
    .stream_data_o  (stream_data),
    .stream_valid_o (stream_valid),
    .stream_width_i (stream_width),
    .stream_ack_i   (stream_ack),
    .drained_o      (drained),
`ifdef DECODE_UNPACK_BITCNT_EN
    .bit_cnt_o      (bit_cnt),
`endif
    .err_o          (err)
  );

  typedef struct {
    logic        valid;
    logic [12:0] data;
    logic        ready;
    logic        drained;
    logic        err;
    logic [31:0] bitcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the stream as a plain queue of bits, oldest first.
  bit     mq[$];
  bit     m_last = 0;
  bit     m_err  = 0;
  longint m_bits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic [31:0] d,
                      input logic l, input logic a, input logic [3:0] w);
    exp_t e;
    int   cnt;
    int   n;
    @(posedge clk);
    #1;
    rst = r; flush = f; in_valid = v; in_data = d; in_last = l;
    stream_ack = a; stream_width = w;

    cnt       = mq.size();
    e.valid   = (cnt >= 13) || (m_last && cnt != 0);
    e.data    = '0;
    for (int i = 0; i < 13; i++)
      if (i < cnt) e.data[12-i] = mq[i];
    e.ready   = !r && !f && !m_last && cnt <= 32;
    e.drained = m_last && cnt == 0;
    e.err     = m_err;
    e.bitcnt  = 32'(m_bits);
    exp_q.push_back(e);

    if (r || f) begin
      mq.delete();
      m_last = 0; m_err = 0; m_bits = 0;
    end else begin
      if (a) begin
        if (!e.valid || w == 0 || w > 13) begin
          m_err = 1;
        end else begin
          n = int'(w);
          if (n > cnt) begin
            n = cnt;
            m_err = 1;
          end
          repeat (n) void'(mq.pop_front());
          m_bits = m_bits + n;
          if (m_bits > 64'hFFFF_FFFF) m_bits = 64'hFFFF_FFFF;
        end
      end
      if (v && e.ready) begin
        for (int i = 31; i >= 0; i--) mq.push_back(d[i]);
        if (l) m_last = 1;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 0, 0, 4'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stream_valid", 32'(stream_valid), 32'(e.valid));
        chk("stream_data",  32'(stream_data),  32'(e.data));
        chk("in_ready",     32'(in_ready),     32'(e.ready));
        chk("drained",      32'(drained),      32'(e.drained));
        chk("err",          32'(err),          32'(e.err));
`ifdef DECODE_UNPACK_BITCNT_EN
        chk("bit_cnt",      bit_cnt,           e.bitcnt);
`endif
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic       r, f, v, l, a;
    logic [3:0] w;
    int         p;

    step(1, 0, 0, 32'h0, 0, 0, 4'd0);
    step(1, 0, 0, 32'h0, 0, 0, 4'd0);

    // First word becomes visible one cycle after acceptance.
    step(0, 0, 1, 32'hA5A5_0000, 0, 0, 4'd0);
    idle();

    // Ack 9 three times, dropping below the window; refill at low fill level.
    step(0, 1, 0, 32'h0, 0, 0, 4'd0);
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 4'd0);
    step(0, 0, 0, 32'h0, 0, 1, 4'd9);
    step(0, 0, 0, 32'h0, 0, 1, 4'd9);
    step(0, 0, 0, 32'h0, 0, 1, 4'd9);
    idle();
    step(0, 0, 1, 32'h1234_5678, 0, 0, 4'd0);
    idle();

    // Same-cycle ack and accept at fill level 20.
    step(0, 1, 0, 32'h0, 0, 0, 4'd0);
    step(0, 0, 1, 32'hFFFF_FFFF, 0, 0, 4'd0);
    step(0, 0, 0, 32'h0, 0, 1, 4'd12);
    step(0, 0, 1, 32'h8000_0001, 0, 1, 4'd13);
    idle();
    step(0, 0, 0, 32'h0, 0, 1, 4'd7);
    idle();

    // Final word drained by 13,13,6; no further words accepted.
    step(0, 1, 0, 32'h0, 0, 0, 4'd0);
    step(0, 0, 1, 32'h8000_0000, 1, 0, 4'd0);
    step(0, 0, 1, 32'hDEAD_BEEF, 0, 1, 4'd13);
    step(0, 0, 0, 32'h0, 0, 1, 4'd13);
    step(0, 0, 0, 32'h0, 0, 1, 4'd6);
    step(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 4'd0);
    idle();

    // Error cases: ack while empty, width 0, over-consume in the tail.
    step(0, 1, 0, 32'h0, 0, 0, 4'd0);
    step(0, 0, 0, 32'h0, 0, 1, 4'd5);
    idle();
    step(0, 1, 0, 32'h0, 0, 0, 4'd0);
    step(0, 0, 1, 32'hC3C3_3C3C, 0, 0, 4'd0);
    step(0, 0, 0, 32'h0, 0, 1, 4'd0);
    step(0, 0, 0, 32'h0, 0, 1, 4'd15);
    idle();
    step(0, 1, 0, 32'h0, 0, 0, 4'd0);
    step(0, 0, 1, 32'hF000_000F, 1, 0, 4'd0);
    step(0, 0, 0, 32'h0, 0, 1, 4'd13);
    step(0, 0, 0, 32'h0, 0, 1, 4'd13);
    step(0, 0, 0, 32'h0, 0, 1, 4'd10);
    idle();

    // Flush mid-stream with a word offered.
    step(0, 1, 0, 32'h0, 0, 0, 4'd0);
    step(0, 0, 1, 32'h1111_2222, 0, 0, 4'd0);
    step(0, 0, 0, 32'h0, 0, 1, 4'd4);
    step(0, 1, 1, 32'h3333_4444, 0, 1, 4'd3);
    idle();
    step(0, 0, 1, 32'h5555_6666, 0, 0, 4'd0);
    idle();

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 499) == 0);
      f = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 2) != 0);
      l = ($urandom_range(0, 24) == 0);
      a = 1'($urandom_range(0, 1));
      p = int'($urandom_range(0, 19));
      if (p == 0)      w = 4'd0;
      else if (p == 1) w = 4'($urandom_range(14, 15));
      else             w = 4'($urandom_range(1, 13));
      step(r, f, v, $urandom, l, a, w);
    end

    idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
